dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter SHALL be: STARVE_LIMIT, default 4, range 1..7; consecutive denied host cycles before the host is forced a grant.
REQ-002 Port SHALL be: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port SHALL be: reset  input  1  asynchronous, active-low reset.
REQ-004 Port SHALL be: cpu_req  input  1  CPU data-memory access valid this cycle.
REQ-005 Port SHALL be: cpu_we  input  1  CPU write enable.
REQ-006 Port SHALL be: cpu_addr  input  8  CPU word address.
REQ-007 Port SHALL be: cpu_wdata  input  16  CPU write data.
REQ-008 Port SHALL be: cpu_rdata  output  16  CPU read data, combinational from mem_rdata.
REQ-009 Port SHALL be: cpu_stall  output  1  CPU pipeline must hold the current access.
REQ-010 Port SHALL be: host_req  input  1  host (loader/debug) access request; the host holds it and its fields stable until host_ack.
REQ-011 Port SHALL be: host_we, host_addr, host_wdata  input  1/8/16  host write enable, address, write data.
REQ-012 Port SHALL be: host_rdata  output  16  registered host read data.
REQ-013 Port SHALL be: host_ack  output  1  one-cycle completion pulse.
REQ-014 Port SHALL be: mem_addr, mem_we, mem_wdata  output  8/1/16  data-memory port; mem_rdata  input  16.

Function
REQ-015 FSM SHALL have two states: IDLE (normal arbitration) and ACK (host completion cycle).
REQ-016 In IDLE, host_grant SHALL be host_req AND (NOT cpu_req OR starve_cnt >= STARVE_LIMIT); otherwise a CPU request wins.
REQ-017 In ACK, host_grant SHALL be 0; a CPU request is served; next state is IDLE.
REQ-018 A host grant SHALL drive mem_addr, mem_we, and mem_wdata from the host fields and move the FSM to ACK at the next edge.
REQ-019 A host grant SHALL register host_rdata <= mem_rdata at that edge, and host_ack SHALL be 1 for exactly the following cycle.
REQ-020 Without a host grant, mem_addr and mem_wdata SHALL follow the CPU fields, and mem_we SHALL equal cpu_req AND cpu_we.
REQ-021 cpu_stall SHALL be cpu_req AND host_grant, combinationally; the access latency is 0 cycles for the CPU and 2 cycles for the host (request to ack).
REQ-022 starve_cnt (3 bits) SHALL increment, saturating at 7, in IDLE when host_req=1 and host_grant=0.
REQ-023 starve_cnt SHALL clear on a host grant, hold in ACK, and clear when host_req=0.
REQ-024 With simultaneous requests and starve_cnt < STARVE_LIMIT, the CPU SHALL win and the host SHALL wait without ack.

Reset
REQ-025 While reset=0: state=IDLE, host_ack=0, host_rdata=0, starve_cnt=0, and mem_we=0 and cpu_stall=0 forced.
REQ-026 Reset during a host-grant or ACK cycle SHALL abort it with no ack issued; the host re-presents its request.

Configuration
REQ-027 Macro DMEM_ARB_STALL_STATS_EN, when defined, SHALL add output stall_cnt (16 bits): reset 0, +1 per cycle with cpu_stall=1, saturating at 0xFFFF.
REQ-028 Without DMEM_ARB_STALL_STATS_EN, stall_cnt SHALL not exist, and the remaining behaviour SHALL be identical.

Structure
REQ-029 Shared package dmem_arb_pkg SHALL hold ADDR_W=8, DATA_W=16, and the FSM state type.
REQ-030 The starvation counter SHALL be a sub-module arb_starve_cnt (inputs: inc, clr, limit; output: at_limit); the remaining logic stays in dmem_arbiter.

Verification
REQ-031 CPU write: cpu_req=1, we=1, addr=0x10, wdata=0xBEEF with host idle -> mem_we=1 and cpu_stall=0; the next-cycle CPU read of 0x10 returns 0xBEEF.
REQ-032 Host read: cpu idle, host_req addr=0x10 at cycle 0 -> mem_addr=0x10 at cycle 0; host_ack=1 and host_rdata=0xBEEF at cycle 1; no host grant at cycle 1.
REQ-033 Starvation: cpu_req held high and host_req high from cycle 0 with STARVE_LIMIT=4 -> host granted at cycle 4, cpu_stall=1 only in cycle 4, host_ack at cycle 5, CPU served at cycle 5.
REQ-034 Back-to-back: host_req kept high after ack, cpu idle -> grants at cycles 0, 2, 4, with acks at cycles 1, 3, 5.
REQ-035 Reset mid-operation: reset=0 during a host-grant cycle -> host_ack stays 0, starve_cnt=0, mem_we=0; after release, the host is re-served normally.
REQ-036 With DMEM_ARB_STALL_STATS_EN: run the REQ-033 scenario twice -> stall_cnt=2, and reset returns it to 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: bus widths, starvation
// counter width and the arbitration FSM state type.
package dmem_arb_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 3;

   localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } arbState_t;

   // Saturating increment used by the starvation counter.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
      return (value == CNT_MAX) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Starvation counter: counts consecutive cycles the host has been denied
// and flags when that count has reached the configured limit.
module arb_starve_cnt
   import dmem_arb_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   input  logic [CNT_W-1:0] limit,
   output logic             at_limit
);

   logic [CNT_W-1:0] r_count;

   // Clear has priority over increment; count saturates at its maximum.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc) begin
         r_count <= satInc(r_count);
      end
   end

   assign at_limit = (r_count >= limit);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between a CPU (zero-latency, wins by default) and a
// host loader/debug port (two-cycle request-to-ack, forced through after
// STARVE_LIMIT consecutive denied cycles).
// Optional macro DMEM_ARB_STALL_STATS_EN adds a saturating stall_cnt output.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STALL_STATS_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arbState_t         r_state;
   arbState_t         w_nextState;
   logic              w_hostGrant;
   logic              w_atLimit;
   logic              w_starveInc;
   logic              w_starveClr;
   logic              r_hostAck;
   logic [DATA_W-1:0] r_hostRdata;

   // Grant decision and next state; the host only wins from IDLE, and never
   // while reset is asserted so an in-flight grant is simply dropped.
   always_comb begin
      w_nextState = ST_IDLE;
      w_hostGrant = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_hostGrant = reset && host_req && (!cpu_req || w_atLimit);
            if (w_hostGrant) begin
               w_nextState = ST_ACK;
            end
         end
         ST_ACK: begin
            w_nextState = ST_IDLE;
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Host completion: capture read data on the grant edge, pulse ack next cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_hostAck   <= 1'b0;
         r_hostRdata <= '0;
      end else begin
         r_hostAck <= w_hostGrant;
         if (w_hostGrant) begin
            r_hostRdata <= mem_rdata;
         end
      end
   end

   // Memory port steering; writes are suppressed entirely during reset.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_req && cpu_we;
      if (w_hostGrant) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         mem_we    = host_we;
      end
      if (!reset) begin
         mem_we = 1'b0;
      end
   end

   assign cpu_stall  = cpu_req && w_hostGrant;
   assign cpu_rdata  = mem_rdata;
   assign host_ack   = r_hostAck;
   assign host_rdata = r_hostRdata;

   // The counter holds through the ACK cycle even if the host keeps
   // requesting, so back-to-back host traffic does not build up credit.
   assign w_starveInc = (r_state == ST_IDLE) && host_req && !w_hostGrant;
   assign w_starveClr = w_hostGrant || !host_req;

   arb_starve_cnt u_starve (
      .clock    (clock),
      .reset    (reset),
      .inc      (w_starveInc),
      .clr      (w_starveClr),
      .limit    (LIMIT),
      .at_limit (w_atLimit)
   );

`ifdef DMEM_ARB_STALL_STATS_EN
   logic [15:0] r_stallCnt;

   // Saturating count of cycles in which the CPU was held off.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stallCnt <= '0;
      end else if (cpu_stall && (r_stallCnt != 16'hFFFF)) begin
         r_stallCnt <= r_stallCnt + 16'd1;
      end
   end

   assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// traffic checked through a scoreboard against a cycle-level reference model.
// Builds with or without DMEM_ARB_STALL_STATS_EN.
module tb_dmem_arbiter;

   localparam int LIMIT    = 4;
   localparam int N_RANDOM = 3000;

   typedef struct packed {
      logic        rst;
      logic        stall;
      logic        memWe;
      logic [7:0]  memAddr;
      logic [15:0] memWdata;
      logic [15:0] cpuRdata;
      logic        ack;
   } expRec_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_req;
   logic        cpu_we;
   logic [7:0]  cpu_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        cpu_stall;
   logic        host_req;
   logic        host_we;
   logic [7:0]  host_addr;
   logic [15:0] host_wdata;
   logic [15:0] host_rdata;
   logic        host_ack;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
`ifdef DMEM_ARB_STALL_STATS_EN
   logic [15:0] stall_cnt;
`endif

   logic [15:0] mem [256];
   logic [15:0] refMem [256];
   logic        memClear;

   int          checks = 0;
   int          failures = 0;

   expRec_t     expQ[$];
   logic [15:0] ackQ[$];
   expRec_t     monRec;
   expRec_t     expRec;
   bit          monitorOn = 1'b0;

   logic        cReq, cWe, hWe;
   logic [7:0]  cAddr, hAddr;
   logic [15:0] cWdata, hWdata;
   bit          hostBusy, inAck, grant, ackNow, doReset, allowNew;
   int          denied;

   dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .host_ack   (host_ack),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STALL_STATS_EN
      ,
      .stall_cnt  (stall_cnt)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clock = ~clock;

   // Data memory behind the arbiter: asynchronous read, synchronous write.
   assign mem_rdata = mem[mem_addr];

   // Memory write port, with a bulk clear used only at start-up.
   always @(posedge clock) begin
      if (memClear) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      end else if (mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic creq, input logic cwe, input logic [7:0] caddr,
                                input logic [15:0] cwdata, input logic hreq, input logic hwe,
                                input logic [7:0] haddr, input logic [15:0] hwdata);
      @(posedge clock);
      #1;
      cpu_req    = creq;
      cpu_we     = cwe;
      cpu_addr   = caddr;
      cpu_wdata  = cwdata;
      host_req   = hreq;
      host_we    = hwe;
      host_addr  = haddr;
      host_wdata = hwdata;
   endtask

   // Starvation scenario: both sides request from cycle 0, host forced at cycle LIMIT.
   task automatic runStarve();
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, 1'b0, 8'h33, 16'h0000, 1'b1, 1'b0, 8'h44, 16'h0000);
         @(negedge clock);
         checkOutput($sformatf("starve c%0d cpu_stall", c), 16'(cpu_stall), (c == 4) ? 16'd1 : 16'd0);
         checkOutput($sformatf("starve c%0d host_ack", c), 16'(host_ack), (c == 5) ? 16'd1 : 16'd0);
         checkOutput($sformatf("starve c%0d mem_addr", c), 16'(mem_addr), (c == 4) ? 16'h0044 : 16'h0033);
         if (c == 5) checkOutput("starve host_rdata", host_rdata, refMem[8'h44]);
      end
   endtask

   // Scoreboard monitor: compares each predicted cycle, and pops expected read data on each ack.
   always @(negedge clock) begin
      if (monitorOn && expQ.size() > 0) begin
         monRec = expQ.pop_front();
         if (monRec.rst) begin
            checkOutput("rst cpu_stall", 16'(cpu_stall), 16'd0);
            checkOutput("rst mem_we", 16'(mem_we), 16'd0);
            checkOutput("rst host_ack", 16'(host_ack), 16'd0);
            checkOutput("rst host_rdata", host_rdata, 16'h0000);
         end else begin
            checkOutput("rnd cpu_stall", 16'(cpu_stall), 16'(monRec.stall));
            checkOutput("rnd mem_we", 16'(mem_we), 16'(monRec.memWe));
            checkOutput("rnd mem_addr", 16'(mem_addr), 16'(monRec.memAddr));
            checkOutput("rnd mem_wdata", mem_wdata, monRec.memWdata);
            checkOutput("rnd cpu_rdata", cpu_rdata, monRec.cpuRdata);
            checkOutput("rnd host_ack", 16'(host_ack), 16'(monRec.ack));
         end
         if (host_ack === 1'b1) begin
            if (ackQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL rnd unexpected ack: got host_ack=1 expected no pending host access");
            end else begin
               checkOutput("rnd host_rdata", host_rdata, ackQ.pop_front());
            end
         end
      end
   end

   // Main sequence: reset, directed scenarios, then randomized traffic.
   initial begin
      reset      = 1'b0;
      memClear   = 1'b1;
      cpu_req    = 1'b0;
      cpu_we     = 1'b0;
      cpu_addr   = 8'h00;
      cpu_wdata  = 16'h0000;
      host_req   = 1'b0;
      host_we    = 1'b0;
      host_addr  = 8'h00;
      host_wdata = 16'h0000;
      for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;

      // Reset with both sides requesting writes: everything must stay quiet.
      for (int c = 0; c < 2; c++) begin
         applyStimulus(1'b1, 1'b1, 8'h10, 16'hAAAA, 1'b1, 1'b1, 8'h20, 16'h5555);
         @(negedge clock);
         checkOutput("reset mem_we", 16'(mem_we), 16'd0);
         checkOutput("reset cpu_stall", 16'(cpu_stall), 16'd0);
         checkOutput("reset host_ack", 16'(host_ack), 16'd0);
         checkOutput("reset host_rdata", host_rdata, 16'h0000);
      end
      @(posedge clock);
      #1;
      reset    = 1'b1;
      memClear = 1'b0;
      cpu_req  = 1'b0;
      host_req = 1'b0;

      // CPU write then read-back.
      applyStimulus(1'b1, 1'b1, 8'h10, 16'hBEEF, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clock);
      checkOutput("cpu write mem_we", 16'(mem_we), 16'd1);
      checkOutput("cpu write cpu_stall", 16'(cpu_stall), 16'd0);
      checkOutput("cpu write mem_addr", 16'(mem_addr), 16'h0010);
      checkOutput("cpu write mem_wdata", mem_wdata, 16'hBEEF);
      refMem[8'h10] = 16'hBEEF;
      applyStimulus(1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clock);
      checkOutput("cpu read cpu_rdata", cpu_rdata, 16'hBEEF);
      checkOutput("cpu read mem_we", 16'(mem_we), 16'd0);

      // Host read with the CPU idle.
      applyStimulus(1'b0, 1'b0, 8'h22, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
      @(negedge clock);
      checkOutput("host read c0 mem_addr", 16'(mem_addr), 16'h0010);
      checkOutput("host read c0 host_ack", 16'(host_ack), 16'd0);
      checkOutput("host read c0 mem_we", 16'(mem_we), 16'd0);
      applyStimulus(1'b0, 1'b0, 8'h22, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
      @(negedge clock);
      checkOutput("host read c1 host_ack", 16'(host_ack), 16'd1);
      checkOutput("host read c1 host_rdata", host_rdata, 16'hBEEF);
      checkOutput("host read c1 no grant", 16'(mem_addr), 16'h0022);

      runStarve();

      // Back-to-back host reads with the CPU idle.
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b0, 1'b0, 8'h66, 16'h0000, 1'b1, 1'b0, 8'h10, 16'h0000);
         @(negedge clock);
         checkOutput($sformatf("b2b c%0d host_ack", c), 16'(host_ack), 16'(c % 2));
         checkOutput($sformatf("b2b c%0d mem_addr", c), 16'(mem_addr), (c % 2 == 0) ? 16'h0010 : 16'h0066);
         if (c % 2 == 1) checkOutput($sformatf("b2b c%0d host_rdata", c), host_rdata, 16'hBEEF);
      end

      // Reset arriving during a forced host-write grant aborts it.
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b1, 1'b0, 8'h66, 16'h0000, 1'b1, 1'b1, 8'h50, 16'h1234);
      end
      @(negedge clock);
      checkOutput("abort grant mem_addr", 16'(mem_addr), 16'h0050);
      checkOutput("abort grant mem_we", 16'(mem_we), 16'd1);
      #1;
      reset  = 1'b0;
      cpu_we = 1'b1;
      #1;
      checkOutput("abort mem_we", 16'(mem_we), 16'd0);
      checkOutput("abort cpu_stall", 16'(cpu_stall), 16'd0);
      checkOutput("abort starve_cnt", 16'(dut.u_starve.r_count), 16'd0);
      @(negedge clock);
      checkOutput("abort host_ack", 16'(host_ack), 16'd0);
      checkOutput("abort host_rdata", host_rdata, 16'h0000);
      @(posedge clock);
      #1;
      reset   = 1'b1;
      cpu_req = 1'b0;
      cpu_we  = 1'b0;
      @(negedge clock);
      checkOutput("reserve grant mem_addr", 16'(mem_addr), 16'h0050);
      checkOutput("reserve grant mem_we", 16'(mem_we), 16'd1);
      applyStimulus(1'b0, 1'b0, 8'h66, 16'h0000, 1'b1, 1'b1, 8'h50, 16'h1234);
      @(negedge clock);
      checkOutput("reserve host_ack", 16'(host_ack), 16'd1);
      checkOutput("reserve host_rdata", host_rdata, refMem[8'h50]);
      refMem[8'h50] = 16'h1234;
      applyStimulus(1'b1, 1'b0, 8'h50, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clock);
      checkOutput("reserve readback", cpu_rdata, 16'h1234);

`ifdef DMEM_ARB_STALL_STATS_EN
      @(posedge clock);
      #1;
      reset   = 1'b0;
      cpu_req = 1'b0;
      @(negedge clock);
      checkOutput("stall_cnt in reset", stall_cnt, 16'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      runStarve();
      runStarve();
      applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
      @(negedge clock);
      checkOutput("stall_cnt two starves", stall_cnt, 16'd2);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      checkOutput("stall_cnt cleared", stall_cnt, 16'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
`endif

      // Randomized traffic against the reference model.
      hostBusy = 1'b0;
      inAck    = 1'b0;
      denied   = 0;
      hWe      = 1'b0;
      hAddr    = 8'h00;
      hWdata   = 16'h0000;
      for (int cyc = 0; cyc < N_RANDOM; cyc++) begin
         allowNew = (cyc < N_RANDOM - 12);
         doReset  = (cyc > 10) && (cyc < N_RANDOM - 25) && ($urandom_range(0, 79) == 0);
         if (!hostBusy && allowNew && ($urandom_range(0, 2) == 0)) begin
            hostBusy = 1'b1;
            hWe      = 1'($urandom_range(0, 1));
            hAddr    = 8'($urandom_range(0, 15));
            hWdata   = 16'($urandom);
         end
         cReq   = ($urandom_range(0, 9) < 7);
         cWe    = 1'($urandom_range(0, 1));
         cAddr  = 8'($urandom_range(0, 15));
         cWdata = 16'($urandom);
         applyStimulus(cReq, cWe, cAddr, cWdata, hostBusy, hWe, hAddr, hWdata);
         reset     = doReset ? 1'b0 : 1'b1;
         monitorOn = 1'b1;

         expRec = '0;
         if (doReset) begin
            expRec.rst = 1'b1;
            inAck      = 1'b0;
            denied     = 0;
            ackQ.delete();
         end else begin
            ackNow          = inAck;
            grant           = !inAck && hostBusy && (!cReq || denied >= LIMIT);
            expRec.stall    = cReq && grant;
            expRec.memWe    = grant ? hWe : (cReq && cWe);
            expRec.memAddr  = grant ? hAddr : cAddr;
            expRec.memWdata = grant ? hWdata : cWdata;
            expRec.cpuRdata = refMem[expRec.memAddr];
            expRec.ack      = ackNow;
            if (grant) ackQ.push_back(refMem[hAddr]);
            if (expRec.memWe) refMem[expRec.memAddr] = expRec.memWdata;
            if (grant || !hostBusy) denied = 0;
            else if (!ackNow) denied = (denied < 7) ? denied + 1 : 7;
            inAck = grant;
            if (ackNow) hostBusy = 1'b0;
         end
         expQ.push_back(expRec);
      end
      @(negedge clock);
      #1;
      checkOutput("drain expQ", 16'(expQ.size()), 16'd0);
      checkOutput("drain ackQ", 16'(ackQ.size()), 16'd0);
      monitorOn = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
